// File: rtl/pipe_decode_reg.sv
// IF/ID pipeline register for the RV32I core.
// Captures the fetched instruction, its PC and PC+4, and presents them to
// decode one cycle later. Supports stall (enabler low) and flush (bubble
// insertion via sync_reset). Every output comes straight from a flop, so no
// input reaches an output combinationally.
module pipe_decode_reg #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clock,
    // Despite its name this reset is sampled only at the rising edge.
    input  logic                  async_reset,
    input  logic                  sync_reset,
    input  logic                  enabler,
    input  logic [DATA_WIDTH-1:0] instruction_F,
    input  logic [DATA_WIDTH-1:0] PC_F,
    input  logic [DATA_WIDTH-1:0] PC_plus_4_F,
    output logic [DATA_WIDTH-1:0] instruction_D,
    output logic [DATA_WIDTH-1:0] PC_D,
    output logic [DATA_WIDTH-1:0] PC_plus_4_D
);

    logic [DATA_WIDTH-1:0] instr_d, instr_q;
    logic [DATA_WIDTH-1:0] pc_d, pc_q;
    logic [DATA_WIDTH-1:0] pc_plus_4_d, pc_plus_4_q;

    // Bubble when either reset is low; reset and flush both produce a NOP.
    logic bubble;
    assign bubble = !async_reset || !sync_reset;

    // Next-state selection: bubble beats load, load beats hold.
    // All three fields always move together.
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc_plus_4_d = pc_plus_4_q;
        if (bubble) begin
            instr_d     = NOP_INSTR;
            pc_d        = '0;
            pc_plus_4_d = '0;
        end else if (enabler) begin
            instr_d     = instruction_F;
            pc_d        = PC_F;
            pc_plus_4_d = PC_plus_4_F;
        end
    end

    // Pipeline state; no reset branch is needed because the reset is folded
    // into the next-state logic above and is therefore synchronous.
    always_ff @(posedge clock) begin
        instr_q     <= instr_d;
        pc_q        <= pc_d;
        pc_plus_4_q <= pc_plus_4_d;
    end

    assign instruction_D = instr_q;
    assign PC_D          = pc_q;
    assign PC_plus_4_D   = pc_plus_4_q;

endmodule

// File: tb/tb_pipe_decode_reg.sv
// Self-checking bench for pipe_decode_reg: a table of directed vectors, one
// clock edge each, plus a hand-written sequence for between-edge stability.
module tb_pipe_decode_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        async_reset;
    logic        sync_reset;
    logic        enabler;
    logic [31:0] instruction_F;
    logic [31:0] PC_F;
    logic [31:0] PC_plus_4_F;
    logic [31:0] instruction_D;
    logic [31:0] PC_D;
    logic [31:0] PC_plus_4_D;

    pipe_decode_reg #(
        .DATA_WIDTH (32),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clock         (clock),
        .async_reset   (async_reset),
        .sync_reset    (sync_reset),
        .enabler       (enabler),
        .instruction_F (instruction_F),
        .PC_F          (PC_F),
        .PC_plus_4_F   (PC_plus_4_F),
        .instruction_D (instruction_D),
        .PC_D          (PC_D),
        .PC_plus_4_D   (PC_plus_4_D)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ar;
        logic        sr;
        logic        en;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev_instr, prev_pc, prev_pc4;

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s[%0d]: got %h, want %h", name, idx, got, want);
    endtask

    initial begin
        async_reset   = 1'b0;
        sync_reset    = 1'b1;
        enabler       = 1'b0;
        instruction_F = '0;
        PC_F          = '0;
        PC_plus_4_F   = '0;

        //         ar    sr    en    instr         pc        pc4         exp instr     exp pc    exp pc4
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h12345678, 32'h9ABCDEF0, NOP, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h003100F8, 32'h0,  32'h4,  32'h003100F8, 32'h0,  32'h4};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h8,  32'hC,  32'h003100F8, 32'h0,  32'h4};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h8,  32'hC,  32'h003100F8, 32'h0,  32'h4};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h8,  32'hC,  32'h003100F8, 32'h0,  32'h4};
        // Flush beats enable, then load resumes.
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h00500093, 32'h10, 32'h14, NOP,          32'h0,  32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h00500093, 32'h10, 32'h14, 32'h00500093, 32'h10, 32'h14};
        // Streaming with a one-edge reset in the middle.
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h00A00113, 32'h18, 32'h1C, 32'h00A00113, 32'h18, 32'h1C};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h00B00193, 32'h1C, 32'h20, NOP,          32'h0,  32'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h00C00213, 32'h20, 32'h24, 32'h00C00213, 32'h20, 32'h24};
        // Both resets low, then release with enabler low: no load.
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h77777777, 32'h24, 32'h28, NOP,          32'h0,  32'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h11111111, 32'h4,  32'h8,  NOP,          32'h0,  32'h0};
        // Back-to-back pipelining.
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h00100093, 32'h0,  32'h4,  32'h00100093, 32'h0,  32'h4};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h00200113, 32'h4,  32'h8,  32'h00200113, 32'h4,  32'h8};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h00300193, 32'h8,  32'hC,  32'h00300193, 32'h8,  32'hC};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h00400213, 32'hC,  32'h10, 32'h00400213, 32'hC,  32'h10};
        // Flush while stalled still inserts a bubble.
        vecs[16] = '{1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 32'h10, 32'h14, NOP,          32'h0,  32'h0};
        // PC+4 is passed through, not recomputed.
        vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h12345678, 32'h40, 32'h99, 32'h12345678, 32'h40, 32'h99};

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            async_reset   = vecs[i].ar;
            sync_reset    = vecs[i].sr;
            enabler       = vecs[i].en;
            instruction_F = vecs[i].instr;
            PC_F          = vecs[i].pc;
            PC_plus_4_F   = vecs[i].pc4;
            // Before the edge the outputs must still show the previous result.
            if (i > 0) begin
                #1;
                check("pre_instr", i, instruction_D, prev_instr);
                check("pre_pc",    i, PC_D,          prev_pc);
                check("pre_pc4",   i, PC_plus_4_D,   prev_pc4);
            end
            @(posedge clock);
            #1;
            check("instr", i, instruction_D, vecs[i].exp_instr);
            check("pc",    i, PC_D,          vecs[i].exp_pc);
            check("pc4",   i, PC_plus_4_D,   vecs[i].exp_pc4);
            prev_instr = vecs[i].exp_instr;
            prev_pc    = vecs[i].exp_pc;
            prev_pc4   = vecs[i].exp_pc4;
        end

        // Hand-written: inputs wiggle between edges with enabler high; outputs
        // only move at the edge.
        @(negedge clock);
        instruction_F = 32'h0AAA0AAA;
        PC_F          = 32'h80;
        PC_plus_4_F   = 32'h84;
        #1;
        instruction_F = 32'h0BBB0BBB;
        PC_F          = 32'h90;
        PC_plus_4_F   = 32'h94;
        #1;
        check("mid_instr", 0, instruction_D, 32'h12345678);
        check("mid_pc",    0, PC_D,          32'h40);
        check("mid_pc4",   0, PC_plus_4_D,   32'h99);
        @(posedge clock);
        #1;
        check("seq_instr", 0, instruction_D, 32'h0BBB0BBB);
        check("seq_pc",    0, PC_D,          32'h90);
        check("seq_pc4",   0, PC_plus_4_D,   32'h94);

        // Long stall: several edges with changing inputs, values must hold.
        enabler = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            instruction_F = 32'hF0000000 + k;
            PC_F          = 32'h100 + 4 * k;
            PC_plus_4_F   = 32'h104 + 4 * k;
            @(posedge clock);
            #1;
            check("stall_instr", k, instruction_D, 32'h0BBB0BBB);
            check("stall_pc",    k, PC_D,          32'h90);
            check("stall_pc4",   k, PC_plus_4_D,   32'h94);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
